rotate_sequencer: RTL and testbench

- Control stage directly upstream of the 8-bit rotating register; generates all of that register's control inputs.
- Accepts a start command carrying a load pattern, direction, shift mode, step count and rate.
- Issues one parallel-load cycle, then a programmed number of rotate/shift clock-enable ticks at a selectable rate, then reports completion.
- The register is clocked by the system clock and advances only on cycles where reg_en=1.

---
 rtl/rotate_sequencer_if.sv | 28 ++
 rtl/rotate_sequencer.sv | 101 ++++++++++
 tb/tb_rotate_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rotate_sequencer_if.sv
// rtl/rotate_sequencer_if.sv - command and register-control bundle for the rotate sequencer
interface rotate_sequencer_if;
    logic       start;
    logic [7:0] data_in;
    logic       dir_right;
    logic       arith;
    logic [1:0] rate_sel;
    logic [3:0] num_steps;
    logic       stop;
    logic [7:0] par_data;
    logic       par_load_n;
    logic       rotate_right;
    logic       as_right;
    logic       reg_en;
    logic       busy;
    logic       done;
    logic [3:0] step_count;

    modport master (
        output start, data_in, dir_right, arith, rate_sel, num_steps, stop,
        input  par_data, par_load_n, rotate_right, as_right, reg_en, busy, done, step_count
    );

    modport slave (
        input  start, data_in, dir_right, arith, rate_sel, num_steps, stop,
        output par_data, par_load_n, rotate_right, as_right, reg_en, busy, done, step_count
    );
endinterface

// File: rtl/rotate_sequencer.sv
// rtl/rotate_sequencer.sv - load-then-tick control sequencer for the 8-bit rotating register
module rotate_sequencer #(
    parameter int DIV_WIDTH = 26,
    parameter int RATE1     = 4,
    parameter int RATE2     = 16,
    parameter int RATE3     = 50000000
) (
    input  logic                clock,
    input  logic                reset,
    rotate_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state;
    logic [1:0]           rate_q;
    logic [3:0]           steps_q;
    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] period_m1;
    logic [DIV_WIDTH-1:0] div_next;
    logic                 tick;
    logic                 finished;

    // The divider register holds the value for the cycle being presented, so
    // reg_en is high exactly while divider==P-1 and stop sampled on the edge
    // that would open a tick cycle suppresses that tick.
    always_comb begin
        period_m1 = '0;
        case (rate_q)
            2'd1:    period_m1 = DIV_WIDTH'(RATE1 - 1);
            2'd2:    period_m1 = DIV_WIDTH'(RATE2 - 1);
            2'd3:    period_m1 = DIV_WIDTH'(RATE3 - 1);
            default: period_m1 = '0;
        endcase
        div_next = '0;
        if (state == RUN && divider != period_m1)
            div_next = divider + DIV_WIDTH'(1);
        tick     = (div_next == period_m1);
        finished = (steps_q != 4'd0) && (bus.step_count == steps_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            rate_q           <= 2'd0;
            steps_q          <= 4'd0;
            divider          <= '0;
            bus.par_data     <= 8'd0;
            bus.par_load_n   <= 1'b1;
            bus.rotate_right <= 1'b0;
            bus.as_right     <= 1'b0;
            bus.reg_en       <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.step_count   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.reg_en <= 1'b0;
                    bus.done   <= 1'b0;
                    if (bus.start) begin
                        state            <= LOAD;
                        bus.par_data     <= bus.data_in;
                        bus.rotate_right <= bus.dir_right;
                        bus.as_right     <= bus.arith;
                        rate_q           <= bus.rate_sel;
                        steps_q          <= bus.num_steps;
                        divider          <= '0;
                        bus.step_count   <= 4'd0;
                        bus.par_load_n   <= 1'b0;
                        bus.reg_en       <= 1'b1;
                        bus.busy         <= 1'b1;
                    end
                end
                LOAD, RUN: begin
                    bus.par_load_n <= 1'b1;
                    if (state == RUN && bus.stop) begin
                        state      <= IDLE;
                        bus.reg_en <= 1'b0;
                        bus.busy   <= 1'b0;
                    end else if (state == RUN && finished) begin
                        state      <= DONE;
                        bus.reg_en <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                    end else begin
                        state      <= RUN;
                        divider    <= div_next;
                        bus.reg_en <= tick;
                        if (tick)
                            bus.step_count <= bus.step_count + 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb/tb_rotate_sequencer.sv - scoreboard bench for rotate_sequencer
module tb_rotate_sequencer;
    typedef struct {
        int          cyc;
        logic [17:0] sig;
    } event_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_evt = 0;
    event_t exp_q[$];

    rotate_sequencer_if bus();

    rotate_sequencer #(
        .DIV_WIDTH(26), .RATE1(4), .RATE2(16), .RATE3(50000000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [17:0] pack(input logic en, input logic pln, input logic dn,
                                         input logic bsy, input logic [3:0] sc,
                                         input logic [7:0] pd, input logic rr, input logic ar);
        return {en, pln, dn, bsy, sc, pd, rr, ar};
    endfunction

    function automatic logic [17:0] observed();
        return pack(bus.reg_en, bus.par_load_n, bus.done, bus.busy, bus.step_count,
                    bus.par_data, bus.rotate_right, bus.as_right);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle that shows a load, tick or done pulse consumes one expected event.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && (bus.reg_en || bus.done || !bus.par_load_n)) begin
                n_evt++;
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_event@%0d", cyc), {14'd0, observed()}, 32'h0);
                end else begin
                    event_t e;
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (e.cyc != cyc || e.sig !== observed()) begin
                        n_bad++;
                        $display("FAIL event%0d: got cyc %0d sig %h expected cyc %0d sig %h",
                                 n_evt, cyc, observed(), e.cyc, e.sig);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Issues a start at the current negedge; LOAD is visible in the next cycle L.
    task automatic do_start(input logic [7:0] d, input logic dr, input logic ar,
                            input logic [1:0] rs, input logic [3:0] n, input int p,
                            input int ticks, input bit exp_done, output int l);
        event_t e;
        l = cyc + 1;
        e.cyc = l;
        e.sig = pack(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, d, dr, ar);
        exp_q.push_back(e);
        for (int k = 1; k <= ticks; k++) begin
            e.cyc = l + k * p;
            e.sig = pack(1'b1, 1'b1, 1'b0, 1'b1, 4'(k), d, dr, ar);
            exp_q.push_back(e);
        end
        if (exp_done) begin
            e.cyc = l + 1 + int'(n) * p;
            e.sig = pack(1'b0, 1'b1, 1'b1, 1'b0, n, d, dr, ar);
            exp_q.push_back(e);
        end
        bus.data_in   = d;
        bus.dir_right = dr;
        bus.arith     = ar;
        bus.rate_sel  = rs;
        bus.num_steps = n;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        bus.start = 0; bus.data_in = 0; bus.dir_right = 0; bus.arith = 0;
        bus.rate_sel = 0; bus.num_steps = 0; bus.stop = 0;
        repeat (2) @(negedge clock);
        check("reset_state", {14'd0, observed()}, {14'd0, pack(0, 1, 0, 0, 0, 8'h00, 0, 0)});
        reset = 1'b0;
        @(negedge clock);

        // Reset in the cycle after the third tick of an 8-step run.
        do_start(8'h3C, 1'b0, 1'b1, 2'd0, 4'd8, 1, 3, 1'b0, l);
        wait_cyc(l + 3);
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset", {14'd0, observed()}, {14'd0, pack(0, 1, 0, 0, 0, 8'h00, 0, 0)});
        reset = 1'b0;
        @(negedge clock);

        do_start(8'hA5, 1'b1, 1'b0, 2'd0, 4'd3, 1, 3, 1'b1, l);
        wait_cyc(l + 5);
        check("a5_after_done_busy", {31'd0, bus.busy}, 32'd0);
        check("a5_final_step", {28'd0, bus.step_count}, 32'd3);

        do_start(8'h81, 1'b0, 1'b0, 2'd1, 4'd2, 4, 2, 1'b1, l);
        wait_cyc(l + 10);
        check("rate1_after_done_busy", {31'd0, bus.busy}, 32'd0);

        // Free-run with wrap, then abort after the twentieth tick.
        do_start(8'h0F, 1'b1, 1'b0, 2'd0, 4'd0, 1, 20, 1'b0, l);
        wait_cyc(l + 20);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        check("wrap_stop_reg_en", {31'd0, bus.reg_en}, 32'd0);
        check("wrap_stop_busy", {31'd0, bus.busy}, 32'd0);
        check("wrap_stop_step", {28'd0, bus.step_count}, 32'd4);

        // Stop sampled on the edge that would open the first rate-2 tick cycle.
        do_start(8'h5A, 1'b0, 1'b0, 2'd2, 4'd5, 16, 0, 1'b0, l);
        wait_cyc(l + 15);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        check("stop_tick_reg_en", {31'd0, bus.reg_en}, 32'd0);
        check("stop_tick_step", {28'd0, bus.step_count}, 32'd0);
        check("stop_tick_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clock);
        check("stop_tick_idle_quiet", {30'd0, bus.reg_en, bus.done}, 32'd0);

        // A start pulse mid-run must be dropped.
        do_start(8'h96, 1'b1, 1'b1, 2'd1, 4'd3, 4, 3, 1'b1, l);
        wait_cyc(l + 5);
        bus.data_in = 8'hFF; bus.arith = 1'b0; bus.dir_right = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("ignored_start_par_data", {24'd0, bus.par_data}, 32'h96);
        wait_cyc(l + 15);
        check("ignored_start_busy", {31'd0, bus.busy}, 32'd0);
        check("ignored_start_latched", {22'd0, bus.par_data, bus.rotate_right, bus.as_right},
              {22'd0, 8'h96, 1'b1, 1'b1});

        repeat (3) @(negedge clock);
        check("events_outstanding", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
